l4_backtrace_ctl: RTL

Backtrace sequencer for the L4 maze-routing accelerator. After wavefront expansion, it walks from the target cell back to the source cell. At each cell it reads the stored predecessor direction code and steps an X/Y coordinate pair with up/down counters. Each visited cell can optionally be marked as part of the routed path. It sits between the accelerator's top-level control and the grid-cell memory port.

---
 rtl/l4_backtrace_ctl_pkg.sv | 33 +++
 rtl/l4_coord_ctr.sv | 24 ++
 rtl/l4_backtrace_ctl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/l4_backtrace_ctl_pkg.sv
// Shared definitions for the L4 backtrace sequencer: direction codes, FSM encoding,
// default coordinate width and the off-grid step test.
package l4_pkg;

    localparam int L4_NBITS = 5;

    localparam logic [1:0] DIR_N = 2'b00;  // y+1
    localparam logic [1:0] DIR_S = 2'b01;  // y-1
    localparam logic [1:0] DIR_E = 2'b10;  // x+1
    localparam logic [1:0] DIR_W = 2'b11;  // x-1

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_READ,
        S_STEP,
        S_FIN,
        S_ERR
    } state_t;

    // True when stepping in direction d from a cell on the given edges leaves the grid.
    function automatic logic off_grid(input logic [1:0] d, input logic x_hi, input logic x_lo,
                                      input logic y_hi, input logic y_lo);
        case (d)
            DIR_N:   off_grid = y_hi;
            DIR_S:   off_grid = y_lo;
            DIR_E:   off_grid = x_hi;
            default: off_grid = x_lo;
        endcase
    endfunction

endpackage

// File: rtl/l4_coord_ctr.sv
// One coordinate axis of the backtrace walk: NBITS up/down counter,
// priority load > up > down.
module l4_coord_ctr
    import l4_pkg::*;
#(
    parameter int NBITS = L4_NBITS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             lden,
    input  logic             upen,
    input  logic             dnen,
    input  logic [NBITS-1:0] din,
    output logic [NBITS-1:0] q
);

    always_ff @(posedge clk) begin
        if (!resetn)   q <= '0;
        else if (lden) q <= din;
        else if (upen) q <= q + 1'b1;
        else if (dnen) q <= q - 1'b1;
    end

endmodule

// File: rtl/l4_backtrace_ctl.sv
// L4 backtrace sequencer: walks predecessor codes from target back to source.
// Path marking (MARK state, wr_req/wr_ack) exists only when L4_BT_MARK_EN is defined.
module l4_backtrace_ctl
    import l4_pkg::*;
#(
    parameter int NBITS = L4_NBITS,
    parameter int SBITS = 2*NBITS+1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [NBITS-1:0] src_x,
    input  logic [NBITS-1:0] src_y,
    input  logic [NBITS-1:0] tgt_x,
    input  logic [NBITS-1:0] tgt_y,
    output logic             rd_req,
    input  logic             rd_ack,
    input  logic             dir_vld,
    input  logic [1:0]       dir,
    output logic             wr_req,
    input  logic             wr_ack,
    output logic [NBITS-1:0] cur_x,
    output logic [NBITS-1:0] cur_y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SBITS-1:0] path_len
);

    localparam logic [SBITS-1:0] LOOP_LIM = SBITS'(1) << (2*NBITS);

    state_t           state;
    logic [1:0]       dir_q;
    logic             lden;
    logic             x_up, x_dn, y_up, y_dn;
    logic             bad_step;
    logic [SBITS-1:0] len_inc;

    assign lden    = (state == S_LOAD);
    assign x_up    = (state == S_STEP) && (dir_q == DIR_E);
    assign x_dn    = (state == S_STEP) && (dir_q == DIR_W);
    assign y_up    = (state == S_STEP) && (dir_q == DIR_N);
    assign y_dn    = (state == S_STEP) && (dir_q == DIR_S);
    assign len_inc = path_len + 1'b1;
    assign bad_step = !dir_vld || off_grid(dir, &cur_x, ~|cur_x, &cur_y, ~|cur_y);

    l4_coord_ctr #(.NBITS(NBITS)) u_ctr_x (
        .clk(clk), .resetn(resetn), .lden(lden), .upen(x_up), .dnen(x_dn),
        .din(tgt_x), .q(cur_x)
    );

    l4_coord_ctr #(.NBITS(NBITS)) u_ctr_y (
        .clk(clk), .resetn(resetn), .lden(lden), .upen(y_up), .dnen(y_dn),
        .din(tgt_y), .q(cur_y)
    );

`ifdef L4_BT_MARK_EN
    logic at_src;
    assign at_src = (cur_x == src_x) && (cur_y == src_y);
`else
    // Without marking, the source decision is made on the coordinate the counters
    // are about to take, so the walk skips straight to READ or FIN.
    logic [NBITS-1:0] nxt_x, nxt_y;
    logic             nxt_at_src, tgt_at_src;
    wire              unused_wr_ack = wr_ack;

    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        case (dir_q)
            DIR_N:   nxt_y = cur_y + 1'b1;
            DIR_S:   nxt_y = cur_y - 1'b1;
            DIR_E:   nxt_x = cur_x + 1'b1;
            default: nxt_x = cur_x - 1'b1;
        endcase
    end

    assign nxt_at_src = (nxt_x == src_x) && (nxt_y == src_y);
    assign tgt_at_src = (tgt_x == src_x) && (tgt_y == src_y);
    assign wr_req     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            rd_req   <= 1'b0;
`ifdef L4_BT_MARK_EN
            wr_req   <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            path_len <= '0;
            dir_q    <= DIR_N;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_LOAD;
                    busy     <= 1'b1;
                    err      <= 1'b0;
                    path_len <= '0;
                end
`ifdef L4_BT_MARK_EN
                S_LOAD: begin
                    state  <= S_MARK;
                    wr_req <= 1'b1;
                end
                S_MARK: if (wr_ack) begin
                    wr_req <= 1'b0;
                    if (at_src) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        state  <= S_READ;
                        rd_req <= 1'b1;
                    end
                end
`else
                S_LOAD: if (tgt_at_src) begin
                    state <= S_FIN;
                    done  <= 1'b1;
                end else begin
                    state  <= S_READ;
                    rd_req <= 1'b1;
                end
`endif
                S_READ: if (rd_ack) begin
                    rd_req <= 1'b0;
                    if (bad_step) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        dir_q <= dir;
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    path_len <= len_inc;
                    if (len_inc == LOOP_LIM) begin
                        state <= S_ERR;
                        err   <= 1'b1;
`ifdef L4_BT_MARK_EN
                    end else begin
                        state  <= S_MARK;
                        wr_req <= 1'b1;
                    end
`else
                    end else if (nxt_at_src) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        state  <= S_READ;
                        rd_req <= 1'b1;
                    end
`endif
                end
                S_FIN, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
